// File: rtl/spi_reg_writer_pkg.sv
// Shared register-map constants for the SPI register writer: group address ranges,
// frame-state encoding and the write-group decoder.
package reg_map_pkg;

  localparam logic [7:0] VERSION_ADDR = 8'h00;
  localparam logic [7:0] MOSI_LO      = 8'h02;
  localparam logic [7:0] MOSI_HI      = 8'h05;
  localparam logic [7:0] GATE_LO      = 8'h20;
  localparam logic [7:0] GATE_HI      = 8'h22;
  localparam logic [7:0] DAC_LO       = 8'h23;
  localparam logic [7:0] DAC_HI       = 8'h25;
  localparam logic [7:0] CNT_LO       = 8'h26;
  localparam logic [7:0] CNT_HI       = 8'h35;
  localparam logic [7:0] PWM_LO       = 8'h36;
  localparam logic [7:0] PWM_HI       = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic mosi;
    logic gate;
    logic dac;
    logic counter;
    logic pwm;
  } wr_strobe_t;

  // Ranges are disjoint, so at most one field is ever set.
  function automatic wr_strobe_t decode_group(input logic [7:0] a);
    wr_strobe_t s;
    s = wr_strobe_t'(5'b00000);
    if (a >= MOSI_LO && a <= MOSI_HI) begin
      s.mosi = 1'b1;
    end else if (a >= GATE_LO && a <= GATE_HI) begin
      s.gate = 1'b1;
    end else if (a >= DAC_LO && a <= DAC_HI) begin
      s.dac = 1'b1;
    end else if (a >= CNT_LO && a <= CNT_HI) begin
      s.counter = 1'b1;
    end else if (a >= PWM_LO && a <= PWM_HI) begin
      s.pwm = 1'b1;
    end else begin
      s = wr_strobe_t'(5'b00000);
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_reg_writer_if.sv
// SPI pin and register-bus bundle between the SPI front end (slave) and its
// environment (master: board pins plus register groups).
interface spi_reg_writer_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] rd_data;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       wr_mosi;
  logic       wr_gate;
  logic       wr_dac;
  logic       wr_counter;
  logic       wr_pwm;
  logic       frame_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rd_data,
    output spi_miso, addr, wr_data, wr_mosi, wr_gate, wr_dac, wr_counter, wr_pwm, frame_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rd_data,
    input  spi_miso, addr, wr_data, wr_mosi, wr_gate, wr_dac, wr_counter, wr_pwm, frame_err
  );
endinterface

// File: rtl/spi_reg_writer_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall pulses derived
// from the synchronised history.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign lvl  = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 slave that turns {wr, addr[6:0]}, data frames into register write strobes.
// Define SPI_REG_WRITER_MISO_EN to include the read-back TX shifter on spi_miso.
module spi_reg_writer
  import reg_map_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  spi_reg_writer_if.slave  bus
);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_sclk),
    .lvl(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // cs_n resets low so a select held low across reset never looks like a fresh fall.
  sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_cs_n),
    .lvl(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_mosi),
    .lvl(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  frame_state_e state_r, state_nxt_s;
  logic [2:0]   bit_cnt_r;
  logic [6:0]   rx_r;
  logic         wr_flag_r;
  logic [7:0]   addr_r;
  logic [7:0]   wr_data_r;
  wr_strobe_t   strobe_r;
  logic         frame_err_r;
  logic         start_s, shift_in_s, addr_done_s, data_done_s, abort_s;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle frame controls; cs_n rise takes priority over sclk.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    shift_in_s  = 1'b0;
    addr_done_s = 1'b0;
    data_done_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = ST_ADDR;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else if (sclk_rise_s && bit_cnt_r == 3'd7) begin
          shift_in_s  = 1'b1;
          addr_done_s = (state_r == ST_ADDR);
          data_done_s = (state_r == ST_DATA);
          state_nxt_s = (state_r == ST_ADDR) ? ST_DATA : ST_HOLD;
        end else if (sclk_rise_s) begin
          shift_in_s  = 1'b1;
          state_nxt_s = state_r;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HOLD: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Receive datapath: bit counter, shift register, address/data capture, strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r   <= 3'd0;
      rx_r        <= 7'd0;
      wr_flag_r   <= 1'b0;
      addr_r      <= 8'h00;
      wr_data_r   <= 8'h00;
      strobe_r    <= wr_strobe_t'(5'b00000);
      frame_err_r <= 1'b0;
    end else begin
      strobe_r    <= wr_strobe_t'(5'b00000);
      frame_err_r <= abort_s;
      if (start_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_in_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (shift_in_s) begin
        rx_r <= {rx_r[5:0], mosi_s};
      end
      if (addr_done_s) begin
        addr_r    <= {1'b0, rx_r[5:0], mosi_s};
        wr_flag_r <= rx_r[6];
      end
      if (data_done_s && wr_flag_r) begin
        wr_data_r <= {rx_r, mosi_s};
        strobe_r  <= decode_group(addr_r);
      end
    end
  end

  assign bus.addr       = addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.wr_mosi    = strobe_r.mosi;
  assign bus.wr_gate    = strobe_r.gate;
  assign bus.wr_dac     = strobe_r.dac;
  assign bus.wr_counter = strobe_r.counter;
  assign bus.wr_pwm     = strobe_r.pwm;
  assign bus.frame_err  = frame_err_r;

`ifdef SPI_REG_WRITER_MISO_EN
  logic       load_r;
  logic [7:0] tx_r;

  // The falling edge right after the 8th rise precedes the first data bit, so it is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r <= 1'b0;
      tx_r   <= 8'h00;
    end else begin
      load_r <= addr_done_s;
      if (load_r) begin
        tx_r <= bus.rd_data;
      end else if (state_r == ST_DATA && sclk_fall_s && bit_cnt_r != 3'd0) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end
    end
  end

  assign bus.spi_miso = (state_r == ST_DATA) ? tx_r[7] : 1'b0;

  logic unused_s;
  assign unused_s = ^{sclk_lvl_s, cs_lvl_s, mosi_rise_s, mosi_fall_s};
`else
  assign bus.spi_miso = 1'b0;

  logic unused_s;
  assign unused_s = ^{sclk_lvl_s, cs_lvl_s, mosi_rise_s, mosi_fall_s, bus.rd_data};
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Randomised scoreboard bench for spi_reg_writer: a frame-level model predicts
// strobe/frame_err events, a monitor pops and compares them as the DUT emits them.
module tb_spi_reg_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_writer_if bus_if();

  spi_reg_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;   // 0 mosi, 1 gate, 2 dac, 3 counter, 4 pwm, 5 frame_err
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Group ranges straight from the address map, in decimal.
  function automatic int group_of(input logic [6:0] a);
    int v;
    v = int'(a);
    if (v >= 2 && v <= 5) return 0;
    if (v >= 32 && v <= 34) return 1;
    if (v >= 35 && v <= 37) return 2;
    if (v >= 38 && v <= 53) return 3;
    if (v >= 54 && v <= 70) return 4;
    return -1;
  endfunction

  // Monitor: any strobe or frame_err must match the head of the expected queue.
  always @(negedge clk) begin
    int   nhi;
    int   kind;
    ev_t  ev;
    if (rst_n) begin
      nhi = int'(bus_if.wr_mosi) + int'(bus_if.wr_gate) + int'(bus_if.wr_dac)
          + int'(bus_if.wr_counter) + int'(bus_if.wr_pwm) + int'(bus_if.frame_err);
      if (nhi > 0) begin
        tests++;
        kind = bus_if.wr_mosi ? 0 : bus_if.wr_gate ? 1 : bus_if.wr_dac ? 2 :
               bus_if.wr_counter ? 3 : bus_if.wr_pwm ? 4 : 5;
        if (nhi > 1) begin
          fails++;
          $display("FAIL onehot: got %0d outputs high, expected 1", nhi);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", kind, bus_if.wr_data);
        end else begin
          ev = exp_q.pop_front();
          if (kind != ev.kind || (kind < 5 && bus_if.wr_data !== ev.data)) begin
            fails++;
            $display("FAIL event: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                     kind, bus_if.wr_data, ev.kind, ev.data);
          end
        end
      end
    end
  end

  task automatic sclk_bit(input logic b);
    bus_if.spi_mosi = b;
    repeat (8) @(negedge clk);
    bus_if.spi_sclk = 1'b1;
    repeat (8) @(negedge clk);
    bus_if.spi_sclk = 1'b0;
  endtask

  // One chip-select frame of nbits bits taken MSB-first from bits.
  task automatic run_frame(input logic [23:0] bits, input int nbits, input logic [7:0] rdv);
    logic [7:0] b0;
    logic [7:0] b1;
    logic       exp_miso;
    int         g;
    ev_t        ev;
    b0 = bits[23:16];
    b1 = bits[15:8];
    g  = group_of(b0[6:0]);
    if (nbits >= 8) exp_addr = {1'b0, b0[6:0]};
    if (nbits < 16) begin
      ev.kind = 5; ev.data = 8'h00; exp_q.push_back(ev);
    end else if (b0[7] && g >= 0) begin
      ev.kind = g; ev.data = b1; exp_q.push_back(ev);
    end
    bus_if.rd_data  = rdv;
    bus_if.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus_if.spi_mosi = bits[23-i];
      repeat (8) @(negedge clk);
`ifdef SPI_REG_WRITER_MISO_EN
      exp_miso = (i >= 8 && i < 16) ? rdv[15-i] : 1'b0;
`else
      exp_miso = 1'b0;
`endif
      check("miso_bit", {31'd0, bus_if.spi_miso}, {31'd0, exp_miso});
      bus_if.spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus_if.spi_sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    bus_if.spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check("pending_events", exp_q.size(), 32'd0);
    exp_q.delete();
    check("addr", {24'd0, bus_if.addr}, {24'd0, exp_addr});
  endtask

  logic [7:0] bnd_tab [14] = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h1F, 8'h20, 8'h22,
                               8'h23, 8'h25, 8'h26, 8'h35, 8'h36, 8'h46, 8'h47};

  initial begin
    logic [7:0] a;
    int         n;
    bus_if.spi_sclk = 1'b0;
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_mosi = 1'b0;
    bus_if.rd_data  = 8'h00;
    repeat (4) @(negedge clk);
    check("reset_addr", {24'd0, bus_if.addr}, 32'h00);
    check("reset_wr_data", {24'd0, bus_if.wr_data}, 32'h00);
    check("reset_outputs", {26'd0, bus_if.wr_mosi, bus_if.wr_gate, bus_if.wr_dac,
          bus_if.wr_counter, bus_if.wr_pwm, bus_if.frame_err}, 32'h0);
    check("reset_miso", {31'd0, bus_if.spi_miso}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(24'hA45A00, 16, 8'h00);
    run_frame(24'hC61100, 16, 8'h00);
    run_frame(24'h80FF00, 16, 8'h00);
    run_frame(24'h260000, 16, 8'hC3);
    run_frame(24'hA0AB00, 11, 8'h00);
    run_frame(24'hA36600, 16, 8'h00);
    run_frame(24'hB007FF, 24, 8'h00);

    foreach (bnd_tab[k]) begin
      a = bnd_tab[k];
      run_frame({1'b1, a[6:0], 8'(k * 17 + 3), 8'h00}, 16, 8'h00);
    end

    // Reset mid-frame with cs_n held low: nothing may happen until cs_n toggles.
    bus_if.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) sclk_bit(i < 8 ? 1'b1 : 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_addr", {24'd0, bus_if.addr}, 32'h00);
    check("midreset_wr_data", {24'd0, bus_if.wr_data}, 32'h00);
    exp_addr = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) sclk_bit(1'b1);
    repeat (8) @(negedge clk);
    bus_if.spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_addr", {24'd0, bus_if.addr}, 32'h00);
    run_frame(24'hA55500, 16, 8'h00);

    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 16;
      run_frame({1'($urandom_range(0, 1)), 7'($urandom_range(0, 72)), 16'($urandom)},
                n, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_writer.md
# spi_reg_writer

SPI slave front end for the control register bus: deserialises two-byte SPI frames, drives the read address into the register read-data selector, shifts the selected byte back on MISO, and issues one-cycle write strobes to the scratch, gate, DAC, counter and PWM register groups. It sits between the board SPI pins and the register groups, and is the write/serial end of the same address map the read selector decodes.

## Interface
- Parameters: none. Address map constants live in the shared package.
- clk  in  1  system clock; must be at least 8x spi_sclk.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  SPI serial data in, MSB first.
- spi_miso  out  1  SPI serial data out, MSB first.
- rd_data  in  8  read byte returned by the selector for addr.
- addr  out  8  register address, {1'b0, frame byte0[6:0]}.
- wr_data  out  8  write byte, valid while any wr_* strobe is high.
- wr_mosi / wr_gate / wr_dac / wr_counter / wr_pwm  out  1 each  one-clk write strobes per group.
- frame_err  out  1  one-clk pulse on an aborted frame.

## Operation
- spi_sclk, spi_cs_n, spi_mosi pass through 2-flop synchronisers; sclk rise/fall detected from synchronised history.
- Frame: byte0 = {wr, a[6:0]}, byte1 = data. wr=1 write, wr=0 read.
- States: IDLE -> ADDR on cs_n fall; ADDR -> DATA after 8th rising edge; DATA -> HOLD after 16th rising edge; HOLD -> IDLE on cs_n rise. cs_n rise in ADDR or DATA -> IDLE with frame_err pulse, no strobe.
- Rising sclk edges beyond the 16th in HOLD are ignored; no second transaction without cs_n toggle.
- At 8th rising edge: addr loads {0, a[6:0]}; wr flag latched.
- At 16th rising edge: if wr=1, wr_data loads byte1 and the matching strobe pulses: 0x02-0x05 wr_mosi, 0x20-0x22 wr_gate, 0x23-0x25 wr_dac, 0x26-0x35 wr_counter, 0x36-0x46 wr_pwm. Any other address (including 0x00 version) writes nothing, no error.
- At most one strobe high in any cycle. addr and wr_data hold until next update.
- Reset values: state IDLE, bit count 0, addr 0x00, wr_data 0x00, all strobes 0, frame_err 0, spi_miso 0.

## Timing
- Synchroniser + edge detect latency: 3 clk from pin edge to internal event.
- addr valid 1 clk after 8th rising edge detection; rd_data sampled into the TX shifter 1 clk later; shifter MSB on spi_miso immediately.
- spi_miso shifts on each detected falling edge in DATA; driven 0 in IDLE, ADDR, HOLD.
- Write strobe: exactly 1 clk, asserted the clk after 16th rising edge detection.
- Reset asserted mid-frame: all state cleared immediately; after release, frames resume only after a fresh cs_n fall.

## Configuration
- SPI_REG_WRITER_MISO_EN defined: TX shifter present, rd_data returned as above.
- Undefined: no TX shifter, spi_miso tied 0, rd_data ignored; write path unchanged.

## Structure
- Package reg_map_pkg: group range bound constants (MOSI_LO/HI, GATE_LO/HI, DAC_LO/HI, CNT_LO/HI, PWM_LO/HI), VERSION_ADDR, frame-state enum.
- One sub-module: sync_edge (2-flop synchroniser with rise/fall pulse outputs), instantiated for sclk, cs_n, mosi.

## Test plan
- Reset with all inputs idle -> addr 0x00, wr_data 0x00, all strobes 0, spi_miso 0.
- Write frame 0xA4, 0x5A -> addr 0x24, single wr_dac pulse with wr_data 0x5A, no other strobe.
- Write frame 0xC6, 0x11 -> addr 0x46, wr_pwm pulse, wr_data 0x11; write frame 0x80, 0xFF -> addr 0x00, no strobe.
- Read frame 0x26, 0x00 with rd_data=0xC3 -> no strobe, spi_miso bits 1,1,0,0,0,0,1,1 on byte1 rising edges.
- cs_n rises after 11 bits of write frame 0xA0 -> frame_err 1-clk pulse, no strobe, next full frame accepted normally.
- 24 sclk cycles in one frame 0xB0, 0x07, 0xFF -> exactly one wr_counter pulse with wr_data 0x07.
